time_to_bin: RTL and testbench
==============================

Name: time_to_bin

Overview:
- Inverse of the binary-to-time-field converter on the display path: takes a packed HH:MM:SS:CC time (binary-coded fields, 8 bits each) and produces the equivalent centisecond count.
- Used when the user sets a stopwatch or timer value; the result loads the centisecond counter that feeds the display chain.
- Multi-cycle serial shift-add conversion, so there are no wide constant multipliers. Valid/ready handshake on both sides; range errors are flagged.

Parameters:
- MAX_HH, 99, largest accepted hour value (inclusive).
- OUT_W, 32, width of bin_out. Must be >= 26.

Ports:
- clk  input  1  single clock. All logic is rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  time_in is valid.
- in_ready  output  1  block can accept input. High only in IDLE.
- time_in  input  32  [31:24]=hh, [23:16]=mm, [15:8]=ss, [7:0]=cc. Each field is unsigned binary.
- out_valid  output  1  result available. Held until accepted.
- out_ready  input  1  consumer accepts the result.
- bin_out  output  OUT_W  hh*360000 + mm*6000 + ss*100 + cc.
- out_err  output  1  input field out of range. Qualified by out_valid.

Behaviour:
- Reset values (async, immediate on rst_n=0): state=IDLE, in_ready=1, out_valid=0, out_err=0, bin_out=0, accumulator=0.
- States:
  - IDLE: on in_valid&&in_ready, capture time_in and go to CHECK.
  - CHECK (1 cycle): error if hh>MAX_HH, mm>59, ss>59 or cc>99. On error: bin_out=0, out_err=1, go to DONE. Otherwise clear the accumulator and go to ACC.
  - ACC (exactly 32 cycles): fields processed in the order hh, mm, ss, cc, 8 cycles each, LSB first. On cycle i of a field, if field bit i is set, acc += K<<i, with K = 360000, 6000, 100, 1 respectively. After cycle 32, bin_out=acc and go to DONE.
  - DONE: out_valid=1. bin_out and out_err held stable. On out_ready go to IDLE, out_valid=0 next cycle.
- Latency, taking the capture edge as cycle 0:
  - Valid input: out_valid is high from cycle 34.
  - Error: out_valid is high from cycle 2.
- out_ready may already be high when out_valid rises; completion is then a one-cycle DONE.
- in_ready=0 in CHECK, ACC and DONE. in_valid is ignored there, with no queuing. There is a mandatory 1-cycle gap between transactions, because IDLE re-asserts in_ready.
- Accumulator arithmetic is unsigned, OUT_W wide. Shifted constants are zero-extended. No overflow is possible with in-range fields (max 35,999,999 at MAX_HH=99).
- bin_out changes only on the transition into DONE and on reset. It holds the last result in IDLE.
- Reset mid-operation (any state): the transaction is aborted, all outputs return to reset values, and nothing is emitted later.
- out_err and bin_out are don't-care to consumers while out_valid=0, but must still follow the rules above.

Decomposition:
- Shared package time_pkg:
  - constants CS_PER_HOUR=360000, CS_PER_MIN=6000, CS_PER_SEC=100, MAX_MM=59, MAX_SS=59, MAX_CC=99.
  - field bit positions (HH_LSB=24, MM_LSB=16, SS_LSB=8, CC_LSB=0).
  - enum t2b_state_t {IDLE, CHECK, ACC, DONE}.
- One sub-module, time_field_mac:
  - Serial shift-add multiply-accumulate.
  - Inputs: 8-bit field, constant K, start.
  - Output: acc_add for one field over 8 cycles.
  - The top level sequences it over the four fields with a 2-bit field index and a 3-bit bit counter.

Test Plan:
- Reset, then time_in=0x00000000 -> in_ready=1 after reset; out_valid at cycle 34; bin_out=0; out_err=0.
- time_in=0x01020304 (01:02:03:04) -> bin_out=372304, out_err=0, out_valid at cycle 34.
- time_in=0x633B3B63 (99:59:59:99) -> bin_out=35999999, out_err=0.
- time_in=0x003C0000 (mm=60) -> out_valid at cycle 2, out_err=1, bin_out=0. Repeat with cc=100 (0x00000064) -> same response.
- 00:00:01:00 with out_ready held low for 10 cycles after out_valid:
  - out_valid and bin_out=100 remain stable.
  - in_ready=0 throughout, and an in_valid pulse during this time is ignored.
  - After out_ready, out_valid drops the next cycle and in_ready rises.
- Assert rst_n=0 at ACC cycle 10 of 01:00:00:00, then release -> outputs return to reset values immediately and no out_valid follows. A new 00:01:00:00 yields 6000 at cycle 34.

Source files
------------

// File: rtl/time_pkg.sv
// Shared constants and state encoding for the time-field to centisecond converter.
package time_pkg;

    // Centisecond weight of each field
    localparam int unsigned CS_PER_HOUR = 360000;
    localparam int unsigned CS_PER_MIN  = 6000;
    localparam int unsigned CS_PER_SEC  = 100;

    // Largest legal value of each sub-hour field
    localparam logic [7:0] MAX_MM = 8'd59;
    localparam logic [7:0] MAX_SS = 8'd59;
    localparam logic [7:0] MAX_CC = 8'd99;

    // LSB position of each field inside the packed HH:MM:SS:CC word
    localparam int HH_LSB = 24;
    localparam int MM_LSB = 16;
    localparam int SS_LSB = 8;
    localparam int CC_LSB = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        ACC   = 2'd2,
        DONE  = 2'd3
    } t2b_state_t;

endpackage

// File: rtl/time_field_mac.sv
// Serial shift-add multiplier for one 8-bit field: over 8 consecutive cycles it
// presents field[i] ? (k << i) : 0, starting with bit 0 on the start cycle.
module time_field_mac #(
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       field,
    input  logic [OUT_W-1:0] k,
    output logic [OUT_W-1:0] acc_add
);

    logic [6:0]       field_sh;
    logic [OUT_W-1:0] k_sh;
    logic             cur_bit;
    logic [OUT_W-1:0] cur_k;

    // On the start cycle use the raw inputs directly so bit 0 costs no extra cycle.
    always_comb begin
        cur_bit = start ? field[0] : field_sh[0];
        cur_k   = start ? k : k_sh;
        acc_add = cur_bit ? cur_k : '0;
    end

    // Remaining field bits shift right while the constant doubles each cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            field_sh <= '0;
            k_sh     <= '0;
        end else if (start) begin
            field_sh <= field[7:1];
            k_sh     <= k << 1;
        end else begin
            field_sh <= field_sh >> 1;
            k_sh     <= k_sh << 1;
        end
    end

endmodule

// File: rtl/time_to_bin.sv
// Converts a packed HH:MM:SS:CC time into a centisecond count using a serial
// shift-add pass over the four fields (hh, mm, ss, cc; 8 cycles each).
module time_to_bin
    import time_pkg::*;
#(
    parameter int MAX_HH = 99,
    parameter int OUT_W  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      time_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] bin_out,
    output logic             out_err
);

    localparam logic [7:0] MAX_HH_B = MAX_HH[7:0];

    t2b_state_t       state, next_state;
    logic [31:0]      time_q;
    logic [1:0]       field_idx;
    logic [2:0]       bit_cnt;
    logic [OUT_W-1:0] acc;
    logic [OUT_W-1:0] acc_next;
    logic [OUT_W-1:0] acc_add;
    logic [OUT_W-1:0] field_k;
    logic [7:0]       field_val;
    logic             range_err;
    logic             mac_start;
    logic             acc_last;

    // Range check of the captured fields.
    always_comb begin
        range_err = (time_q[HH_LSB +: 8] > MAX_HH_B) ||
                    (time_q[MM_LSB +: 8] > MAX_MM)   ||
                    (time_q[SS_LSB +: 8] > MAX_SS)   ||
                    (time_q[CC_LSB +: 8] > MAX_CC);
    end

    // Select the field being accumulated and its centisecond weight.
    always_comb begin
        field_val = time_q[CC_LSB +: 8];
        field_k   = OUT_W'(1);
        case (field_idx)
            2'd0: begin field_val = time_q[HH_LSB +: 8]; field_k = OUT_W'(CS_PER_HOUR); end
            2'd1: begin field_val = time_q[MM_LSB +: 8]; field_k = OUT_W'(CS_PER_MIN);  end
            2'd2: begin field_val = time_q[SS_LSB +: 8]; field_k = OUT_W'(CS_PER_SEC);  end
            default: begin field_val = time_q[CC_LSB +: 8]; field_k = OUT_W'(1); end
        endcase
    end

    assign mac_start = (state == ACC) && (bit_cnt == 3'd0);
    assign acc_last  = (field_idx == 2'd3) && (bit_cnt == 3'd7);
    assign acc_next  = acc + acc_add;

    time_field_mac #(.OUT_W(OUT_W)) u_mac (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mac_start),
        .field   (field_val),
        .k       (field_k),
        .acc_add (acc_add)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) next_state = CHECK;
            end
            CHECK: next_state = range_err ? DONE : ACC;
            ACC: if (acc_last) next_state = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath: capture, accumulate, and load the result on entry to DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            time_q    <= '0;
            field_idx <= '0;
            bit_cnt   <= '0;
            acc       <= '0;
            bin_out   <= '0;
            out_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) time_q <= time_in;
                CHECK: begin
                    if (range_err) begin
                        bin_out <= '0;
                        out_err <= 1'b1;
                    end else begin
                        acc       <= '0;
                        field_idx <= '0;
                        bit_cnt   <= '0;
                    end
                end
                ACC: begin
                    acc     <= acc_next;
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) field_idx <= field_idx + 2'd1;
                    if (acc_last) begin
                        bin_out <= acc_next;
                        out_err <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_time_to_bin.sv
// Directed bench for time_to_bin: a vector table of transactions plus
// hand-written sequences for back-pressure, zero-wait completion and mid-run reset.
module tb_time_to_bin;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] time_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] bin_out;
    logic        out_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    time_to_bin #(.MAX_HH(99), .OUT_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .time_in   (time_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bin_out   (bin_out),
        .out_err   (out_err)
    );

    typedef struct {
        logic [31:0] t;
        logic [31:0] exp_bin;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Present t for one capture edge; lat = edges after capture until out_valid.
    task automatic do_txn(input logic [31:0] t, output int lat);
        @(negedge clk);
        time_in  = t;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic accept(input string name, input logic [31:0] exp_bin);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({name, " valid_drop"}, 32'(out_valid), 32'd0);
        chk({name, " ready_rise"}, 32'(in_ready), 32'd1);
        chk({name, " bin_hold_idle"}, bin_out, exp_bin);
    endtask

    vec_t vecs[9];
    int   lat;
    logic saw_valid;

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{32'h00000000, 32'd0,        1'b0, 33};
        vecs[1] = '{32'h01020304, 32'd372304,   1'b0, 33};
        vecs[2] = '{32'h633B3B63, 32'd35999999, 1'b0, 33};
        vecs[3] = '{32'h003C0000, 32'd0,        1'b1, 1};
        vecs[4] = '{32'h00000064, 32'd0,        1'b1, 1};
        vecs[5] = '{32'h17000000, 32'd8280000,  1'b0, 33};
        vecs[6] = '{32'h64000000, 32'd0,        1'b1, 1};
        vecs[7] = '{32'h00003C00, 32'd0,        1'b1, 1};
        vecs[8] = '{32'h000A1E32, 32'd63050,    1'b0, 33};

        // Reset state
        #12;
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_err", 32'(out_err), 32'd0);
        chk("rst bin_out", bin_out, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Table-driven transactions
        for (int i = 0; i < 9; i++) begin
            do_txn(vecs[i].t, lat);
            chk($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("v%0d bin_out", i), bin_out, vecs[i].exp_bin);
            chk($sformatf("v%0d out_err", i), 32'(out_err), 32'(vecs[i].exp_err));
            chk($sformatf("v%0d busy_ready", i), 32'(in_ready), 32'd0);
            accept($sformatf("v%0d", i), vecs[i].exp_bin);
        end

        // Back-pressure: result held for 10 cycles, in_valid ignored meanwhile
        do_txn(32'h00000100, lat);
        chk("hold latency", 32'(lat), 32'd33);
        for (int c = 0; c < 10; c++) begin
            if (c == 4) begin
                @(negedge clk); time_in = 32'h01000000; in_valid = 1'b1;
                @(posedge clk); #1; in_valid = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
            chk($sformatf("hold c%0d valid", c), 32'(out_valid), 32'd1);
            chk($sformatf("hold c%0d bin", c), bin_out, 32'd100);
            chk($sformatf("hold c%0d ready", c), 32'(in_ready), 32'd0);
        end
        accept("hold", 32'd100);
        repeat (3) @(posedge clk);
        #1;
        chk("hold no_queued valid", 32'(out_valid), 32'd0);
        chk("hold no_queued ready", 32'(in_ready), 32'd1);

        // out_ready already high: one-cycle DONE
        @(negedge clk); out_ready = 1'b1;
        do_txn(32'h00000207, lat);
        chk("zw latency", 32'(lat), 32'd33);
        chk("zw bin", bin_out, 32'd207);
        @(posedge clk); #1;
        chk("zw valid_drop", 32'(out_valid), 32'd0);
        chk("zw ready_rise", 32'(in_ready), 32'd1);
        @(negedge clk); out_ready = 1'b0;

        // Reset at ACC cycle 10 of 01:00:00:00
        @(negedge clk); time_in = 32'h01000000; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (11) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        #1;
        chk("mid_rst in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst out_err", 32'(out_err), 32'd0);
        chk("mid_rst bin_out", bin_out, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (out_valid) saw_valid = 1'b1;
        end
        chk("mid_rst no_output", 32'(saw_valid), 32'd0);
        do_txn(32'h00010000, lat);
        chk("post_rst latency", 32'(lat), 32'd33);
        chk("post_rst bin", bin_out, 32'd6000);
        chk("post_rst err", 32'(out_err), 32'd0);
        accept("post_rst", 32'd6000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
